sampler_dma_voice_scanner: RTL and testbench

//  Port-B consumer of the DMA descriptor BRAM (128b x 64; one 128b word per voice; the register side writes 32b via port A).
//  On each frame_tick, walks the descriptors and issues one sample-fetch request per active voice.

---
 rtl/sampler_dma_pkg.sv | 43 ++++
 rtl/sampler_dma_desc_update.sv | 50 +++++
 rtl/sampler_dma_voice_scanner.sv | 153 +++++++++++++++
 tb/tb_sampler_dma_voice_scanner.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sampler_dma_pkg.sv
// Shared types and constants for the sampler DMA descriptor scanner.
// One 128-bit BRAM word per voice holds control, status and the current fetch address.
package sampler_dma_pkg;

    localparam int DESC_W          = 128;
    localparam int VOICE_IDX_W     = 6;
    localparam int DESC_WORD_BYTES = 4;

    localparam int BIT_V_START = 32;
    localparam int BIT_V_STOP  = 33;
    localparam int LEN_LSB     = 40;
    localparam int LEN_W       = 24;
    localparam int BIT_ACTIVE  = 64;
    localparam int BIT_DONE    = 65;
    localparam int CA_LSB      = 96;

    typedef struct packed {
        logic [31:0] ca;
        logic [29:0] rsvd_status;
        logic        done;
        logic        active;
        logic [23:0] len;
        logic [5:0]  rsvd_ctrl;
        logic        v_stop;
        logic        v_start;
        logic [31:0] ba;
    } voice_desc_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_EVAL = 3'd2,
        ST_REQ  = 3'd3,
        ST_WB   = 3'd4,
        ST_NEXT = 3'd5
    } scan_state_e;

    // Byte address one past the last sample word of the voice (wraps mod 2^32).
    function automatic logic [31:0] desc_end_addr(input voice_desc_t d);
        return d.ba + {6'd0, d.len, 2'b00};
    endfunction

endpackage

// File: rtl/sampler_dma_desc_update.sv
// Pure combinational descriptor rules: the evaluate step after a BRAM read and
// the address advance after an accepted fetch request.
module sampler_dma_desc_update
    import sampler_dma_pkg::*;
(
    input  voice_desc_t desc_i,
    output voice_desc_t eval_desc_o,
    output logic        eval_req_o,
    output logic        eval_wb_o,
    output voice_desc_t adv_desc_o,
    output logic        adv_last_o
);

    // Evaluate: first matching rule wins; reserved status bits always written back as zero.
    always_comb begin
        eval_desc_o             = desc_i;
        eval_desc_o.rsvd_status = 30'd0;
        eval_req_o              = 1'b0;
        eval_wb_o               = 1'b0;
        if (desc_i.v_stop && desc_i.active) begin
            eval_desc_o.active = 1'b0;
            eval_desc_o.done   = 1'b1;
            eval_wb_o          = 1'b1;
        end else if (!desc_i.v_start || desc_i.done || (desc_i.len == 24'd0)) begin
            eval_req_o = 1'b0;
        end else begin
            if (!desc_i.active) begin
                eval_desc_o.ca     = desc_i.ba;
                eval_desc_o.active = 1'b1;
            end else begin
                eval_desc_o.ca = desc_i.ca;
            end
            eval_req_o = 1'b1;
        end
    end

    // Advance: step the current address one word and retire the voice at the buffer end.
    always_comb begin
        adv_desc_o    = desc_i;
        adv_desc_o.ca = desc_i.ca + 32'(DESC_WORD_BYTES);
        adv_last_o    = (adv_desc_o.ca == desc_end_addr(desc_i));
        if (adv_last_o) begin
            adv_desc_o.active = 1'b0;
            adv_desc_o.done   = 1'b1;
        end else begin
            adv_desc_o.active = desc_i.active;
        end
    end

endmodule

// File: rtl/sampler_dma_voice_scanner.sv
// Per-frame descriptor walker: reads each voice descriptor on BRAM port B, issues at
// most one sample fetch per active voice and writes the updated status/address back.
module sampler_dma_voice_scanner
    import sampler_dma_pkg::*;
#(
    parameter int MAX_VOICES      = 64,
    parameter int BRAM_RD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   frame_tick,
    output logic                   bram_B_we,
    output logic [VOICE_IDX_W-1:0] bram_B_addr,
    output logic [DESC_W-1:0]      bram_B_din,
    input  logic [DESC_W-1:0]      bram_B_dout,
    output logic                   dma_req_valid,
    input  logic                   dma_req_ready,
    output logic [31:0]            dma_req_addr,
    output logic [VOICE_IDX_W-1:0] dma_req_voice,
    output logic                   scan_busy,
    output logic                   frame_overrun
);

    localparam logic [VOICE_IDX_W-1:0] LAST_IDX = VOICE_IDX_W'(MAX_VOICES - 1);
    localparam logic [1:0]             LAT_LAST = 2'(BRAM_RD_LATENCY - 1);

    scan_state_e             state_q, state_d;
    logic [VOICE_IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]              lat_q, lat_d;
    voice_desc_t             desc_q, desc_d;
    logic                    halt_q, halt_d;
    logic                    we_q, valid_q, busy_q, overrun_q;
    logic                    overrun_d;
    logic                    run_s;

    voice_desc_t             upd_in_s, eval_desc_s, adv_desc_s;
    logic                    eval_req_s, eval_wb_s, adv_last_s;

    assign run_s    = start & ~stop;
    assign upd_in_s = (state_q == ST_EVAL) ? voice_desc_t'(bram_B_dout) : desc_q;

    sampler_dma_desc_update u_desc_update (
        .desc_i      (upd_in_s),
        .eval_desc_o (eval_desc_s),
        .eval_req_o  (eval_req_s),
        .eval_wb_o   (eval_wb_s),
        .adv_desc_o  (adv_desc_s),
        .adv_last_o  (adv_last_s)
    );

    // Scan sequencing; a stop seen mid-scan lets the current voice finish, then parks in IDLE.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lat_d     = lat_q;
        desc_d    = desc_q;
        halt_d    = halt_q | ((state_q != ST_IDLE) & stop);
        overrun_d = frame_tick & run_s & (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                halt_d = 1'b0;
                if (frame_tick && run_s) begin
                    state_d = ST_RD;
                    idx_d   = '0;
                    lat_d   = 2'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (lat_q == LAT_LAST) begin
                    state_d = ST_EVAL;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_EVAL: begin
                desc_d = eval_desc_s;
                if (eval_wb_s) begin
                    state_d = ST_WB;
                end else if (eval_req_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_REQ: begin
                if (dma_req_ready) begin
                    desc_d  = adv_desc_s;
                    state_d = ST_WB;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WB: begin
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if ((idx_q == LAST_IDX) || halt_q || stop) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + VOICE_IDX_W'(1);
                    lat_d   = 2'd0;
                    state_d = ST_RD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, holding registers and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            lat_q     <= 2'd0;
            desc_q    <= '0;
            halt_q    <= 1'b0;
            we_q      <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lat_q     <= lat_d;
            desc_q    <= desc_d;
            halt_q    <= halt_d;
            we_q      <= (state_d == ST_WB);
            valid_q   <= (state_d == ST_REQ);
            busy_q    <= (state_d != ST_IDLE);
            overrun_q <= overrun_d;
        end
    end

    assign bram_B_we     = we_q;
    assign bram_B_addr   = idx_q;
    assign bram_B_din    = desc_q;
    assign dma_req_valid = valid_q;
    assign dma_req_addr  = desc_q.ca;
    assign dma_req_voice = idx_q;
    assign scan_busy     = busy_q;
    assign frame_overrun = overrun_q;

    // adv_last_s is folded into adv_desc_s; kept as an observable flag of the sub-module.
    logic unused_s;
    assign unused_s = adv_last_s;

endmodule

// File: tb/tb_sampler_dma_voice_scanner.sv
// Randomized and directed bench: a descriptor-level reference model predicts fetch
// requests and BRAM contents; a monitor compares requests as they handshake.
module tb_sampler_dma_voice_scanner;
    import sampler_dma_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n, start, stop, frame_tick;
    logic         bram_B_we, dma_req_valid, dma_req_ready, scan_busy, frame_overrun;
    logic [5:0]   bram_B_addr, dma_req_voice;
    logic [127:0] bram_B_din, bram_B_dout;
    logic [31:0]  dma_req_addr;

    logic [127:0] mem [64];
    logic [127:0] model [64];
    logic [127:0] saved [64];
    logic         pa_we;
    logic [5:0]   pa_addr;
    logic [127:0] pa_data;
    logic [37:0]  exp_q [$];
    int           total = 0;
    int           bad = 0;
    int           ready_mode = 0;

    always #5 clk = ~clk;

    sampler_dma_voice_scanner #(.MAX_VOICES(64), .BRAM_RD_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .frame_tick(frame_tick),
        .bram_B_we(bram_B_we), .bram_B_addr(bram_B_addr), .bram_B_din(bram_B_din),
        .bram_B_dout(bram_B_dout), .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
        .dma_req_addr(dma_req_addr), .dma_req_voice(dma_req_voice),
        .scan_busy(scan_busy), .frame_overrun(frame_overrun)
    );

    // Dual-port descriptor RAM: port A from the bench, port B from the scanner.
    always @(posedge clk) begin
        if (pa_we) mem[pa_addr] <= pa_data;
        if (bram_B_we) mem[bram_B_addr] <= bram_B_din;
        bram_B_dout <= mem[bram_B_addr];
    end

    task automatic check_v(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_i(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [31:0] ba, input logic [23:0] len,
                                        input logic vs, input logic vp, input logic act,
                                        input logic dn, input logic [31:0] ca);
        logic [127:0] d;
        d = '0;
        d[31:0] = ba;
        d[BIT_V_START] = vs;
        d[BIT_V_STOP] = vp;
        d[LEN_LSB +: LEN_W] = len;
        d[BIT_ACTIVE] = act;
        d[BIT_DONE] = dn;
        d[CA_LSB +: 32] = ca;
        return d;
    endfunction

    // Reference: one frame over voices 0..last_v; predicts requests, new descriptors, scan length.
    task automatic model_scan(input int last_v, output int cyc);
        cyc = 0;
        for (int v = 0; v <= last_v; v++) begin
            logic [127:0] d;
            logic [31:0]  ba, ca;
            logic [23:0]  len;
            d = model[v];
            ba = d[31:0];
            ca = d[CA_LSB +: 32];
            len = d[LEN_LSB +: LEN_W];
            if (d[BIT_V_STOP] && d[BIT_ACTIVE]) begin
                d[BIT_ACTIVE] = 1'b0;
                d[BIT_DONE] = 1'b1;
                cyc += 4;
            end else if (!d[BIT_V_START] || d[BIT_DONE] || len == 24'd0) begin
                cyc += 3;
            end else begin
                if (!d[BIT_ACTIVE]) begin
                    ca = ba;
                    d[BIT_ACTIVE] = 1'b1;
                end
                exp_q.push_back({6'(v), ca});
                ca = ca + 32'd4;
                if (ca == ba + 32'(len) * 32'd4) begin
                    d[BIT_ACTIVE] = 1'b0;
                    d[BIT_DONE] = 1'b1;
                end
                d[CA_LSB +: 32] = ca;
                cyc += 5;
            end
            model[v] = d;
        end
    endtask

    task automatic write_desc(input int v, input logic [127:0] d);
        @(negedge clk);
        pa_we = 1'b1;
        pa_addr = 6'(v);
        pa_data = d;
        @(negedge clk);
        pa_we = 1'b0;
        model[v] = d;
    endtask

    task automatic clear_all();
        for (int v = 0; v < 64; v++) write_desc(v, '0);
    endtask

    // Request driver: 0 = always ready, 1 = random, other = held low.
    initial begin
        dma_req_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: dma_req_ready = 1'b1;
                1: dma_req_ready = 1'($urandom_range(0, 1));
                default: dma_req_ready = 1'b0;
            endcase
        end
    end

    // Monitor: request stability under backpressure, no write-back during REQ, scoreboard pop.
    logic        pend = 1'b0;
    logic [31:0] p_addr;
    logic [5:0]  p_voice;
    always @(negedge clk) begin
        if (!reset_n) begin
            pend = 1'b0;
        end else begin
            if (pend) check_v("req_stable", {dma_req_valid, dma_req_voice, dma_req_addr}, {1'b1, p_voice, p_addr});
            if (dma_req_valid) check_i("wb_during_req", int'(bram_B_we), 0);
            if (dma_req_valid && dma_req_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_req: got voice %0d addr %h expected none", dma_req_voice, dma_req_addr);
                end else begin
                    check_v("req", 128'({dma_req_voice, dma_req_addr}), 128'(exp_q.pop_front()));
                end
            end
            pend = dma_req_valid && !dma_req_ready;
            p_addr = dma_req_addr;
            p_voice = dma_req_voice;
        end
    end

    task automatic run_scan(input int last_v, input bit chk_len, input bit do_ovr, input int stop_v, input int hold);
        int exp_cyc, cyc, ovr, hold_left, ndiff;
        model_scan(last_v, exp_cyc);
        hold_left = hold;
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        check_i("scan_start", int'(scan_busy), 1);
        cyc = 0;
        ovr = 0;
        while (scan_busy && cyc < 6000) begin
            cyc++;
            if (frame_overrun) ovr++;
            frame_tick = (do_ovr && cyc == 5);
            if (stop_v >= 0 && dma_req_valid && dma_req_voice == 6'(stop_v)) stop = 1'b1;
            if (hold_left > 0 && dma_req_valid) begin
                hold_left--;
                if (hold_left == 0) ready_mode = 0;
            end
            @(negedge clk);
        end
        frame_tick = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (frame_overrun) ovr++;
            @(negedge clk);
        end
        check_i("scan_timeout", int'(cyc < 6000), 1);
        if (chk_len) check_i("scan_cycles", cyc, exp_cyc);
        check_i("overrun_pulses", ovr, do_ovr ? 1 : 0);
        check_i("missing_req", exp_q.size(), 0);
        exp_q.delete();
        ndiff = 0;
        for (int v = 0; v < 64; v++) begin
            if (mem[v] !== model[v]) begin
                if (ndiff == 0) $display("FAIL desc_mem voice %0d: got %h expected %h", v, mem[v], model[v]);
                ndiff++;
            end
        end
        check_i("desc_mem_diffs", ndiff, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no end expected end of test");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int c;
        reset_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        frame_tick = 1'b0;
        pa_we = 1'b0;
        pa_addr = '0;
        pa_data = '0;
        repeat (3) @(negedge clk);
        check_v("reset_out_a", 128'({bram_B_we, bram_B_addr, dma_req_valid, dma_req_addr, dma_req_voice,
                                      scan_busy, frame_overrun}), 128'd0);
        check_v("reset_din", bram_B_din, 128'd0);
        reset_n = 1'b1;
        clear_all();
        start = 1'b1;

        // LEN=3 voice runs out after three frames.
        write_desc(0, mk(32'h1000_0000, 24'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        for (int i = 0; i < 3; i++) run_scan(63, 1'b1, 1'b0, -1, 0);
        check_v("len3_status", 128'({mem[0][BIT_DONE], mem[0][BIT_ACTIVE], mem[0][CA_LSB +: 32]}),
                128'({1'b1, 1'b0, 32'h1000_000C}));
        run_scan(63, 1'b1, 1'b0, -1, 0);

        // Voices 0, 5, 63 in one frame.
        clear_all();
        write_desc(0, mk(32'h0000_1000, 24'd8, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        write_desc(5, mk(32'h0000_5000, 24'd8, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        write_desc(63, mk(32'h0006_3000, 24'd8, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        run_scan(63, 1'b1, 1'b0, -1, 0);

        // Backpressure for 20 cycles.
        clear_all();
        write_desc(7, mk(32'h4000_0000, 24'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        ready_mode = 3;
        run_scan(63, 1'b0, 1'b0, -1, 20);
        ready_mode = 0;

        // Second tick during a busy scan.
        clear_all();
        write_desc(1, mk(32'h0000_0100, 24'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        write_desc(2, mk(32'h0000_0200, 24'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        run_scan(63, 1'b1, 1'b1, -1, 0);

        // V_STOP on an active voice.
        clear_all();
        write_desc(2, mk(32'h2000_0000, 24'd8, 1'b1, 1'b1, 1'b1, 1'b0, 32'h2000_0010));
        run_scan(63, 1'b1, 1'b0, -1, 0);
        check_v("vstop_status", 128'({mem[2][BIT_DONE], mem[2][BIT_ACTIVE], mem[2][CA_LSB +: 32]}),
                128'({1'b1, 1'b0, 32'h2000_0010}));

        // Global stop while voice 1 is requesting; voices 2 and 3 stay untouched.
        clear_all();
        for (int v = 0; v < 4; v++) write_desc(v, mk(32'h0010_0000 + 32'(v) * 32'h100, 24'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        run_scan(1, 1'b1, 1'b0, 1, 0);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        check_i("tick_ignored_when_stopped", int'({scan_busy, frame_overrun}), 0);
        stop = 1'b0;

        // Reset while a request is pending, then restart from voice 0.
        clear_all();
        write_desc(0, mk(32'h3000_0000, 24'd10, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        for (int v = 0; v < 64; v++) saved[v] = model[v];
        ready_mode = 3;
        model_scan(63, c);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        for (int k = 0; k < 10 && !dma_req_valid; k++) @(negedge clk);
        check_i("req_before_reset", int'(dma_req_valid), 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_i("reset_mid_req", int'({bram_B_we, dma_req_valid, scan_busy}), 0);
        exp_q.delete();
        for (int v = 0; v < 64; v++) model[v] = saved[v];
        @(negedge clk) reset_n = 1'b1;
        ready_mode = 0;
        run_scan(63, 1'b1, 1'b0, -1, 0);

        // Randomized descriptors with random backpressure.
        ready_mode = 1;
        for (int r = 0; r < 6; r++) begin
            for (int v = 0; v < 64; v++) begin
                logic [31:0] ba;
                logic [23:0] len;
                logic        act;
                if ($urandom_range(0, 3) == 0) begin
                    ba = $urandom & 32'hFFFF_FFFC;
                    len = 24'($urandom_range(0, 3));
                    act = 1'($urandom_range(0, 1));
                    write_desc(v, mk(ba, len, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), act,
                                     1'($urandom_range(0, 5) == 0),
                                     act ? ba + 32'd4 * 32'($urandom_range(0, (len > 0) ? int'(len) - 1 : 0)) : $urandom));
                end else begin
                    write_desc(v, '0);
                end
            end
            run_scan(63, 1'b0, 1'b0, -1, 0);
            run_scan(63, 1'b0, 1'b0, -1, 0);
        end
        ready_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
